// File: rtl/wm_pkg.sv
`default_nettype none
// ============================================================================
// wm_pkg : panel state encoding and controller phase timing shared by the
//          washing-machine front-panel sequencer.
// Revision: 1.0
// ============================================================================
package wm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ARM      = 3'd1,
      ST_RUN      = 3'd2,
      ST_PAUSED   = 3'd3,
      ST_COMPLETE = 3'd4,
      ST_FAULT    = 3'd5
   } panel_state_t;

   // Controller phase durations in seconds (one tick per second).
   localparam int FILL_S  = 60;
   localparam int DRAIN_S = 120;
   localparam int WASH_S  = 300;
   localparam int SPIN_S  = 600;

   // Double wash with dry: fill, two wash+spin passes, drain.
   localparam int LONGEST_CYCLE_S = FILL_S + DRAIN_S + 2 * (WASH_S + SPIN_S);

endpackage
`default_nettype wire

// File: rtl/wm_debounce.sv
`default_nettype none
// ============================================================================
// wm_debounce : counter debouncer producing a clean level and a one-cycle
//               rising-edge press event.
// Revision: 1.0
// ============================================================================
module wm_debounce #(
   parameter int DEBOUNCE_CNT = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CNT);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;

   assign cnt_inc = cnt + CW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (btn != level) begin
            if (cnt_inc == LIMIT) begin
               level <= ~level;
               cnt   <= '0;
               press <= ~level;
            end else begin
               cnt <= cnt_inc;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wm_panel_ctrl.sv
`default_nettype none
// ============================================================================
// wm_panel_ctrl : front-panel sequencer driving the washing-machine
//                 controller's start/done interface with ack and watchdog.
// Revision: 1.0
// ============================================================================
module wm_panel_ctrl
   import wm_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 2,
   parameter int ACK_TIMEOUT  = 4,
   parameter int WATCHDOG_CNT = 2100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_pause,
   input  logic       sw_double,
   input  logic       sw_dry,
   input  logic       wm_done,
   output logic       start,
   output logic       double_wash,
   output logic       dry_wash,
   output logic       time_pause,
   output logic       busy,
   output logic       done_led,
   output logic       fault,
   output logic [7:0] cycle_count
);

   localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
   localparam int WD_W  = $clog2(WATCHDOG_CNT + 1);
   localparam logic [ACK_W-1:0] ACK_LIMIT = ACK_W'(ACK_TIMEOUT);
   localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(WATCHDOG_CNT);

   generate
      if (WATCHDOG_CNT <= LONGEST_CYCLE_S) begin : g_wd_check
         $error("WATCHDOG_CNT must exceed the longest legal wash cycle");
      end
   endgenerate

   panel_state_t     state, state_nxt;
   logic             start_level, pause_level, start_press, pause_press;
   logic [ACK_W-1:0] ack_cnt, ack_inc;
   logic [WD_W-1:0]  wd_cnt, wd_inc;
   logic             seen_low, ack_pending, completed, ack_expired, wd_expired;
   logic             latch_opts, enter_complete;
   logic             unused_levels;

   wm_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_start (
      .clk(clk), .rst_n(rst_n), .btn(btn_start), .level(start_level), .press(start_press)
   );

   wm_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_pause (
      .clk(clk), .rst_n(rst_n), .btn(btn_pause), .level(pause_level), .press(pause_press)
   );

   assign unused_levels = start_level ^ pause_level;

   assign ack_inc        = ack_cnt + ACK_W'(1);
   assign wd_inc         = wd_cnt + WD_W'(1);
   assign ack_pending    = !seen_low && wm_done;
   assign completed      = wm_done && seen_low;
   assign ack_expired    = ack_pending && (ack_inc == ACK_LIMIT);
   assign wd_expired     = (wd_inc == WD_LIMIT);
   assign enter_complete = (state_nxt == ST_COMPLETE) && (state != ST_COMPLETE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      latch_opts = 1'b0;
      start      = 1'b0;
      time_pause = 1'b0;
      busy       = 1'b0;
      done_led   = 1'b0;
      fault      = 1'b0;
      case (state)
         ST_IDLE, ST_COMPLETE: begin
            done_led = (state == ST_COMPLETE);
            if (start_press) begin
               state_nxt  = ST_ARM;
               latch_opts = 1'b1;
            end
         end
         ST_ARM: begin
            start     = 1'b1;
            busy      = 1'b1;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            // Completion outranks a timeout expiring on the same edge.
            if (completed)                       state_nxt = ST_COMPLETE;
            else if (ack_expired || wd_expired)  state_nxt = ST_FAULT;
            else if (pause_press)                state_nxt = ST_PAUSED;
         end
         ST_PAUSED: begin
            busy       = 1'b1;
            time_pause = 1'b1;
            if (completed)        state_nxt = ST_COMPLETE;
            else if (pause_press) state_nxt = ST_RUN;
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_cnt  <= '0;
         wd_cnt   <= '0;
         seen_low <= 1'b0;
      end else if (state == ST_ARM) begin
         ack_cnt  <= '0;
         wd_cnt   <= '0;
         seen_low <= 1'b0;
      end else if (state == ST_RUN) begin
         wd_cnt <= wd_inc;
         if (!wm_done)    seen_low <= 1'b1;
         if (ack_pending) ack_cnt  <= ack_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         double_wash <= 1'b0;
         dry_wash    <= 1'b0;
      end else if (latch_opts) begin
         double_wash <= sw_double;
         dry_wash    <= sw_dry;
      end else if (state_nxt == ST_COMPLETE || state_nxt == ST_FAULT) begin
         double_wash <= 1'b0;
         dry_wash    <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)                                      cycle_count <= 8'd0;
      else if (enter_complete && cycle_count != 8'hFF) cycle_count <= cycle_count + 8'd1;
   end

endmodule
`default_nettype wire

// File: tb/tb_wm_panel_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wm_panel_ctrl : directed self-checking bench for wm_panel_ctrl.
// Revision: 1.0
// ============================================================================
module tb_wm_panel_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, btn_start, btn_pause, sw_double, sw_dry, wm_done;
   logic       start, double_wash, dry_wash, time_pause, busy, done_led, fault;
   logic [7:0] cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wm_panel_ctrl dut (
      .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_pause(btn_pause),
      .sw_double(sw_double), .sw_dry(sw_dry), .wm_done(wm_done),
      .start(start), .double_wash(double_wash), .dry_wash(dry_wash),
      .time_pause(time_pause), .busy(busy), .done_led(done_led),
      .fault(fault), .cycle_count(cycle_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {start, double_wash, dry_wash, time_pause, busy, done_led, fault}
   function automatic logic [6:0] outs();
      return {start, double_wash, dry_wash, time_pause, busy, done_led, fault};
   endfunction

   // Three-sample hold: leaves the FSM in ARM when accepted.
   task automatic press_start();
      btn_start = 1'b1;
      tick(); tick(); tick();
      btn_start = 1'b0;
   endtask

   initial begin
      logic bad;
      int   tp_cnt;

      rst_n = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
      sw_double = 1'b0; sw_dry = 1'b0; wm_done = 1'b1;
      tick(); tick();
      check("reset_outs", 32'(outs()), 32'h00);
      check("reset_count", 32'(cycle_count), 32'd0);

      // One-sample glitch must not start a cycle.
      rst_n = 1'b1;
      btn_start = 1'b1;
      tick();
      btn_start = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (start || busy) bad = 1'b1;
      end
      check("glitch_no_start", 32'(bad), 32'd0);

      // Double-wash cycle with full completion.
      sw_double = 1'b1;
      btn_start = 1'b1;
      tick();
      check("lat_edge1", 32'(start), 32'd0);
      tick();
      check("lat_edge2", 32'(start), 32'd0);
      tick();
      btn_start = 1'b0;
      check("arm_outs", 32'(outs()), 32'b1100100);
      sw_double = 1'b0;
      tick();
      check("run_entry_outs", 32'(outs()), 32'b0100100);
      wm_done = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 1980; i++) begin
         tick();
         if (!double_wash || !busy || start || fault || done_led) bad = 1'b1;
      end
      check("run_stable", 32'(bad), 32'd0);
      wm_done = 1'b1;
      tick();
      check("complete_outs", 32'(outs()), 32'b0000010);
      check("complete_count", 32'(cycle_count), 32'd1);

      // Dry cycle paused for 500 cycles starting at RUN cycle 100.
      sw_dry = 1'b1;
      press_start();
      check("dry_arm_outs", 32'(outs()), 32'b1010100);
      sw_dry = 1'b0;
      tick();
      wm_done = 1'b0;
      tp_cnt = 0;
      bad = 1'b0;
      for (int i = 1; i <= 2481; i++) begin
         btn_pause = ((i >= 98 && i <= 100) || (i >= 598 && i <= 600));
         wm_done = (i >= 2481);
         tick();
         if (time_pause) tp_cnt++;
         if (fault) bad = 1'b1;
         if (i == 100) check("pause_entry", 32'(time_pause), 32'd1);
         if (i == 600) check("pause_exit", 32'(time_pause), 32'd0);
      end
      btn_pause = 1'b0;
      check("pause_len", 32'(tp_cnt), 32'd500);
      check("pause_no_fault", 32'(bad), 32'd0);
      check("pause_complete_outs", 32'(outs()), 32'b0000010);
      check("pause_complete_count", 32'(cycle_count), 32'd2);

      // Ack timeout: wm_done never falls.
      press_start();
      tick();
      bad = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         if (fault || !busy) bad = 1'b1;
      end
      check("ack_pre_fault", 32'(bad), 32'd0);
      tick();
      check("ack_fault_outs", 32'(outs()), 32'b0000001);
      press_start();
      tick(); tick();
      check("fault_sticky", 32'(outs()), 32'b0000001);
      check("fault_count_kept", 32'(cycle_count), 32'd2);

      // Mid-RUN reset with the start button held.
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      press_start();
      tick();
      wm_done = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      btn_start = 1'b1;
      rst_n = 1'b0;
      tick(); tick();
      check("midrun_reset_outs", 32'(outs()), 32'h00);
      check("midrun_reset_count", 32'(cycle_count), 32'd0);
      rst_n = 1'b1;
      tick();
      check("post_reset_edge1", 32'(start), 32'd0);
      tick();
      check("post_reset_edge2", 32'(start), 32'd0);
      tick();
      check("post_reset_edge3", 32'(start), 32'd1);
      btn_start = 1'b0;

      // Watchdog: wm_done falls and never rises.
      tick();
      wm_done = 1'b0;
      bad = 1'b0;
      for (int i = 1; i <= 2099; i++) begin
         tick();
         if (fault) bad = 1'b1;
      end
      check("wd_pre_fault", 32'(bad), 32'd0);
      tick();
      check("wd_fault_outs", 32'(outs()), 32'b0000001);

      // Simultaneous start and pause presses from IDLE.
      wm_done = 1'b1;
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      btn_start = 1'b1;
      btn_pause = 1'b1;
      tick(); tick(); tick();
      btn_start = 1'b0;
      btn_pause = 1'b0;
      check("both_arm_outs", 32'(outs()), 32'b1000100);
      tick();
      check("both_run_outs", 32'(outs()), 32'b0000100);
      tick();
      check("both_still_run", 32'(outs()), 32'b0000100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wm_panel_ctrl.md
# wm_panel_ctrl

Front-panel sequencer that drives the Washing_Machine controller's command inputs and consumes its `done` output, i.e. the initiator side of the controller's start/done interface. It debounces the start and pause buttons, latches the wash options at cycle start, and issues a one-cycle `start` pulse. It tracks the controller's `done` handshake, toggles `time_pause`, counts completed cycles, and flags a fault when the controller fails to acknowledge or overruns. It sits between panel I/O and the controller, on the same 1 Hz tick clock (1 clock = 1 s).

## Interface
- DEBOUNCE_CNT, 2, consecutive identical samples required to change a debounced button level
- ACK_TIMEOUT, 4, max cycles after the `start` pulse for `wm_done` to fall
- WATCHDOG_CNT, 2100, max non-paused cycles in RUN before fault; longest legal cycle is 1980
- clk  in  1  system clock, one tick per second
- rst_n  in  1  synchronous, active-low reset
- btn_start  in  1  start button, raw, synchronous to clk
- btn_pause  in  1  pause button, raw, synchronous to clk
- sw_double  in  1  double-wash selector switch
- sw_dry  in  1  dry-wash (steam clean) selector switch
- wm_done  in  1  `done` from the controller
- start  out  1  to controller; one-cycle pulse
- double_wash  out  1  to controller; latched option
- dry_wash  out  1  to controller; latched option
- time_pause  out  1  to controller; high while PAUSED
- busy  out  1  high in ARM, RUN and PAUSED
- done_led  out  1  high in COMPLETE
- fault  out  1  high in FAULT
- cycle_count  out  8  completed cycles, saturating at 255

## Operation
- Debounce, per button: a counter counts consecutive samples that differ from the debounced level. When the count reaches DEBOUNCE_CNT, the debounced level flips and the counter clears. Any matching sample clears the counter. A press event is the debounced 0→1 transition, one cycle wide.
- States: IDLE, ARM, RUN, PAUSED, COMPLETE, FAULT.
- IDLE: all controller outputs 0. A start press latches sw_double and sw_dry into double_wash and dry_wash, then goes to ARM.
- ARM (1 cycle): start=1. Clears the ack counter, watchdog and seen_low, then goes to RUN.
- RUN:
  - seen_low sets when wm_done=0 is sampled.
  - While seen_low=0, the ack counter increments; when it reaches ACK_TIMEOUT the FSM goes to FAULT.
  - The watchdog increments every cycle; when it reaches WATCHDOG_CNT the FSM goes to FAULT.
  - wm_done=1 with seen_low=1 means the cycle completed: go to COMPLETE and increment cycle_count (saturating).
  - A pause press goes to PAUSED.
- PAUSED: time_pause=1, and the watchdog and ack counter hold. A pause press returns to RUN. Completion (wm_done=1 with seen_low=1) goes straight to COMPLETE.
- COMPLETE: options cleared, done_led=1. A start press latches options and goes to ARM.
- FAULT: all controller outputs 0, fault=1. Only rst_n exits.
- Start presses are ignored in ARM, RUN, PAUSED and FAULT. Pause presses are ignored in IDLE, ARM, COMPLETE and FAULT.
- Simultaneous start and pause presses in IDLE or COMPLETE: start wins, pause is discarded.
- Switch changes after the latch have no effect until the next start press.

## Timing
- Reset: on the clock edge where rst_n=0, all outputs go to 0, the FSM goes to IDLE, and both debouncers are cleared to level 0 and count 0. This applies mid-cycle too.
- Start latency: btn_start first sampled high at edge 1 and held. The debounced level flips at edge DEBOUNCE_CNT. `start` is high for exactly the cycle after edge DEBOUNCE_CNT+1, which is the ARM cycle. RUN begins at the next edge.
- Option outputs are valid in the same cycle as `start` and remain stable until COMPLETE, FAULT or reset.
- `time_pause` rises one edge after the debounced pause flip.
- The ack counter samples wm_done starting in the first RUN cycle. With ACK_TIMEOUT=4 and wm_done held high, FAULT is entered at the 4th RUN edge.
- Watchdog: FAULT is entered on the edge where the non-paused RUN cycle count reaches WATCHDOG_CNT. Completion and watchdog expiry on the same edge: completion wins.
- cycle_count updates on the edge entering COMPLETE.

## Structure
- Shared package `wm_pkg` holds:
  - the panel state enum;
  - the controller phase-duration constants (60, 120, 300, 600) already used by the controller;
  - the derived longest-cycle constant (1980), against which WATCHDOG_CNT is checked.
- Sub-module `wm_debounce`, parameterised by DEBOUNCE_CNT, outputs level and press event; instantiated twice.
- FSM, ack counter, watchdog and cycle counter live in the top module.

## Test plan
- Reset: rst_n=0 for 2 clocks mid-RUN with btn_start=1 → all outputs 0 and cycle_count=0. After release, `start` pulses 3 edges after the first high sample.
- Debounce: 1-cycle btn_start glitch → no `start`. With sw_double=1, a 3-cycle hold → `start` high exactly 1 cycle and double_wash=1 for the whole of RUN.
- Full cycle: bench model drops wm_done 1 cycle after `start` and raises it after 1980 cycles → done_led=1, cycle_count=1, busy=0, double_wash=0.
- Pause: pause press at RUN cycle 100, second press 500 cycles later → time_pause high for those 500 cycles. Completion at 1980 non-paused cycles produces no fault.
- Ack fault: wm_done held high after `start` → fault=1 at the 4th RUN edge, outputs 0. A later btn_start press has no effect until reset.
- Watchdog fault: wm_done falls but never rises → fault after exactly 2100 RUN cycles. Separately, start and pause pressed together in IDLE → ARM with time_pause=0.
